// File: rtl/pipeline_hazard_ctrl.sv
// Hazard sequencer for the IF/OF/EX/MA/RW pipeline: RAW stalls, branch flushes, memory hold.
// Define PIPELINE_HAZARD_FORWARD_EN to replace full RAW stalls with load-use stalls plus forward selects.
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_W          = 4,
  parameter int BRANCH_FLUSH_CYCLES = 2,
  parameter int STALL_CNT_W         = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   of_valid,
  input  logic [REG_ADDR_W-1:0]  of_rs1,
  input  logic                   of_rs1_used,
  input  logic [REG_ADDR_W-1:0]  of_rs2,
  input  logic                   of_rs2_used,
  input  logic [REG_ADDR_W-1:0]  of_rd,
  input  logic                   of_is_write,
  input  logic                   of_is_load,
  input  logic                   ex_branch_taken,
  input  logic                   ma_busy,
  output logic                   if_of_en,
  output logic                   of_ex_en,
  output logic                   ex_ma_en,
  output logic                   ma_rw_en,
  output logic                   if_of_flush,
  output logic                   of_ex_flush,
  output logic [1:0]             stall_ctrl,
  output logic [1:0]             fwd_a,
  output logic [1:0]             fwd_b,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  typedef struct packed {
    logic                  v;
    logic [REG_ADDR_W-1:0] rd;
    logic                  w;
    logic                  ld;
  } slot_t;

  typedef enum logic [1:0] {
    MODE_RUN   = 2'b00,
    MODE_STALL = 2'b01,
    MODE_FLUSH = 2'b10,
    MODE_HOLD  = 2'b11
  } mode_e;

  localparam logic [2:0] FLUSH_LOAD = 3'(BRANCH_FLUSH_CYCLES - 1);

  slot_t      ex_slot, ma_slot, rw_slot;
  logic [2:0] flush_cnt;
  logic       branch_pending;
  logic       hazard;
  logic [1:0] fwd_a_sel, fwd_b_sel;
  mode_e      mode;

  function automatic logic slot_match(input slot_t s, input logic [REG_ADDR_W-1:0] r);
    return s.v && s.w && (s.rd == r);
  endfunction

`ifdef PIPELINE_HAZARD_FORWARD_EN
  function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] r);
    if (slot_match(ex_slot, r))      return 2'b01;
    else if (slot_match(ma_slot, r)) return 2'b10;
    else if (slot_match(rw_slot, r)) return 2'b11;
    else                             return 2'b00;
  endfunction

  // Only a load still in EX cannot be forwarded; everything older is bypassed.
  assign hazard = of_valid && ex_slot.ld &&
                  ((of_rs1_used && slot_match(ex_slot, of_rs1)) ||
                   (of_rs2_used && slot_match(ex_slot, of_rs2)));
  assign fwd_a_sel = fwd_sel(of_rs1);
  assign fwd_b_sel = fwd_sel(of_rs2);

  logic unused_slot_bits;
  assign unused_slot_bits = ^{ma_slot.ld, rw_slot.ld};
`else
  function automatic logic any_match(input logic [REG_ADDR_W-1:0] r);
    return slot_match(ex_slot, r) || slot_match(ma_slot, r) || slot_match(rw_slot, r);
  endfunction

  // RW counts: the register file write only becomes readable the cycle after RW.
  assign hazard = of_valid &&
                  ((of_rs1_used && any_match(of_rs1)) ||
                   (of_rs2_used && any_match(of_rs2)));
  assign fwd_a_sel = 2'b00;
  assign fwd_b_sel = 2'b00;

  logic unused_slot_bits;
  assign unused_slot_bits = ^{ex_slot.ld, ma_slot.ld, rw_slot.ld};
`endif

  always_comb begin
    mode = MODE_RUN;
    if (ma_busy)
      mode = MODE_HOLD;
    else if (ex_branch_taken || branch_pending || (flush_cnt != 3'd0))
      mode = MODE_FLUSH;
    else if (hazard)
      mode = MODE_STALL;
  end

  always_comb begin
    if_of_en    = 1'b0;
    of_ex_en    = 1'b0;
    ex_ma_en    = 1'b0;
    ma_rw_en    = 1'b0;
    if_of_flush = 1'b0;
    of_ex_flush = 1'b0;
    stall_ctrl  = 2'b00;
    fwd_a       = 2'b00;
    fwd_b       = 2'b00;
    if (!rst) begin
      stall_ctrl = mode;
      case (mode)
        MODE_RUN: begin
          {if_of_en, of_ex_en, ex_ma_en, ma_rw_en} = 4'b1111;
          fwd_a = fwd_a_sel;
          fwd_b = fwd_b_sel;
        end
        MODE_STALL: begin
          {of_ex_en, ex_ma_en, ma_rw_en} = 3'b111;
          of_ex_flush = 1'b1;
        end
        MODE_FLUSH: begin
          {if_of_en, of_ex_en, ex_ma_en, ma_rw_en} = 4'b1111;
          if_of_flush = 1'b1;
          of_ex_flush = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // A branch seen during HOLD is remembered and starts its flush once memory releases.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_slot        <= '0;
      ma_slot        <= '0;
      rw_slot        <= '0;
      flush_cnt      <= 3'd0;
      branch_pending <= 1'b0;
      stall_cycles   <= '0;
    end else begin
      if (of_ex_en)
        ex_slot <= of_ex_flush ? slot_t'('0) : {of_valid, of_rd, of_is_write, of_is_load};
      if (ex_ma_en)
        ma_slot <= ex_slot;
      if (ma_rw_en)
        rw_slot <= ma_slot;
      if (ma_busy) begin
        branch_pending <= branch_pending | ex_branch_taken;
      end else if (ex_branch_taken || branch_pending) begin
        flush_cnt      <= FLUSH_LOAD;
        branch_pending <= 1'b0;
      end else if (flush_cnt != 3'd0) begin
        flush_cnt <= flush_cnt - 3'd1;
      end
      if ((mode == MODE_STALL) && (stall_cycles != '1))
        stall_cycles <= stall_cycles + STALL_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed scoreboard bench for pipeline_hazard_ctrl; expectations follow the
// PIPELINE_HAZARD_FORWARD_EN setting of the build.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       of_valid, of_rs1_used, of_rs2_used, of_is_write, of_is_load;
  logic [3:0] of_rs1, of_rs2, of_rd;
  logic       ex_branch_taken, ma_busy;
  logic       if_of_en, of_ex_en, ex_ma_en, ma_rw_en, if_of_flush, of_ex_flush;
  logic [1:0] stall_ctrl, fwd_a, fwd_b;
  logic [15:0] stall_cycles;

  pipeline_hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .of_valid(of_valid), .of_rs1(of_rs1), .of_rs1_used(of_rs1_used),
    .of_rs2(of_rs2), .of_rs2_used(of_rs2_used), .of_rd(of_rd),
    .of_is_write(of_is_write), .of_is_load(of_is_load),
    .ex_branch_taken(ex_branch_taken), .ma_busy(ma_busy),
    .if_of_en(if_of_en), .of_ex_en(of_ex_en), .ex_ma_en(ex_ma_en), .ma_rw_en(ma_rw_en),
    .if_of_flush(if_of_flush), .of_ex_flush(of_ex_flush), .stall_ctrl(stall_ctrl),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  en;
    logic [1:0]  fl;
    logic [1:0]  sc;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [15:0] cnt;
  } exp_t;

  typedef struct packed {
    logic       v;
    logic [3:0] rs1;
    logic       u1;
    logic [3:0] rs2;
    logic       u2;
    logic [3:0] rd;
    logic       w;
    logic       ld;
  } ins_t;

  localparam logic [1:0] RUN = 2'b00, STL = 2'b01, FLS = 2'b10, HLD = 2'b11;

  exp_t        sb_q[$];
  string       tag_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_cnt = '0;

  function automatic exp_t mk(input logic [1:0] mode, input logic [1:0] fa,
                              input logic [1:0] fb, input logic [15:0] cnt);
    exp_t e;
    e.sc = mode; e.fa = fa; e.fb = fb; e.cnt = cnt;
    case (mode)
      RUN:     begin e.en = 4'b1111; e.fl = 2'b00; end
      STL:     begin e.en = 4'b0111; e.fl = 2'b01; end
      FLS:     begin e.en = 4'b1111; e.fl = 2'b11; end
      default: begin e.en = 4'b0000; e.fl = 2'b00; end
    endcase
    return e;
  endfunction

  function automatic ins_t ins(input logic v, input logic [3:0] rs1, input logic u1,
                               input logic [3:0] rs2, input logic u2,
                               input logic [3:0] rd, input logic w, input logic ld);
    return {v, rs1, u1, rs2, u2, rd, w, ld};
  endfunction

  task automatic drive(input ins_t i, input logic br, input logic busy);
    of_valid = i.v; of_rs1 = i.rs1; of_rs1_used = i.u1;
    of_rs2 = i.rs2; of_rs2_used = i.u2;
    of_rd = i.rd; of_is_write = i.w; of_is_load = i.ld;
    ex_branch_taken = br; ma_busy = busy;
  endtask

  task automatic apply_stimulus(input ins_t i, input logic br, input logic busy,
                                input logic [1:0] mode, input logic [1:0] fa,
                                input logic [1:0] fb, input string tag);
    drive(i, br, busy);
    sb_q.push_back(mk(mode, fa, fb, exp_cnt));
    tag_q.push_back(tag);
    if (mode == STL) exp_cnt = exp_cnt + 16'd1;
  endtask

  task automatic check_output();
    exp_t  e, obs;
    string t;
    checks++;
    obs = {if_of_en, of_ex_en, ex_ma_en, ma_rw_en, if_of_flush, of_ex_flush,
           stall_ctrl, fwd_a, fwd_b, stall_cycles};
    if (sb_q.size() == 0) begin
      errors++;
      $error("[TB] FAIL scoreboard_empty observed %h expected an entry", obs);
    end else begin
      e = sb_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("[TB] FAIL %s observed en=%b fl=%b sc=%b fa=%b fb=%b cnt=%0d expected en=%b fl=%b sc=%b fa=%b fb=%b cnt=%0d",
               t, obs.en, obs.fl, obs.sc, obs.fa, obs.fb, obs.cnt,
               e.en, e.fl, e.sc, e.fa, e.fb, e.cnt);
      end
    end
  endtask

  task automatic step(input ins_t i, input logic br, input logic busy,
                      input logic [1:0] mode, input logic [1:0] fa,
                      input logic [1:0] fb, input string tag);
    @(posedge clk);
    #1;
    apply_stimulus(i, br, busy, mode, fa, fb, tag);
    @(negedge clk);
    check_output();
  endtask

  task automatic expect_reset(input string tag);
    sb_q.push_back('0);
    tag_q.push_back(tag);
    #1;
    check_output();
  endtask

  initial begin
    #50000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] simulation did not complete");
  end

  initial begin
    ins_t nop, b_ins, c_ins, e_ins, g_ins;
    nop = '0;

    // Reset with busy, branch and a hazard-looking instruction all active.
    rst = 1'b1;
    drive(ins(1'b1, 4'd3, 1'b1, 4'd3, 1'b1, 4'd3, 1'b1, 1'b1), 1'b1, 1'b1);
    #2;
    expect_reset("reset_state");
    @(posedge clk);
    #1;
    drive(nop, 1'b0, 1'b0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++)
      step(ins(1'b1, 4'd1, 1'b1, 4'd2, 1'b1, 4'(8 + i % 4), 1'b1, 1'b0),
           1'b0, 1'b0, RUN, 2'b00, 2'b00, "independent");

    // Dependent ALU pair on r3.
    step(ins(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd3, 1'b1, 1'b0), 1'b0, 1'b0, RUN, 2'b00, 2'b00, "raw_producer");
    b_ins = ins(1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 4'd12, 1'b1, 1'b0);
`ifdef PIPELINE_HAZARD_FORWARD_EN
    step(b_ins, 1'b0, 1'b0, RUN, 2'b01, 2'b00, "raw_fwd_a_ex");
`else
    for (int i = 0; i < 3; i++)
      step(b_ins, 1'b0, 1'b0, STL, 2'b00, 2'b00, "raw_stall");
    step(b_ins, 1'b0, 1'b0, RUN, 2'b00, 2'b00, "raw_release");
`endif

    // Load-use on r5 through source 2.
    step(ins(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd5, 1'b1, 1'b1), 1'b0, 1'b0, RUN, 2'b00, 2'b00, "load_producer");
    c_ins = ins(1'b1, 4'd0, 1'b0, 4'd5, 1'b1, 4'd13, 1'b1, 1'b0);
`ifdef PIPELINE_HAZARD_FORWARD_EN
    step(c_ins, 1'b0, 1'b0, STL, 2'b00, 2'b00, "load_use_stall");
    step(c_ins, 1'b0, 1'b0, RUN, 2'b00, 2'b10, "load_use_fwd_b_ma");
`else
    for (int i = 0; i < 3; i++)
      step(c_ins, 1'b0, 1'b0, STL, 2'b00, 2'b00, "load_use_stall");
    step(c_ins, 1'b0, 1'b0, RUN, 2'b00, 2'b00, "load_use_release");
`endif

    // Taken branch arriving while a hazard is pending wins over the stall.
    step(ins(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd6, 1'b1, 1'b0), 1'b0, 1'b0, RUN, 2'b00, 2'b00, "branch_producer");
    e_ins = ins(1'b1, 4'd6, 1'b1, 4'd0, 1'b0, 4'd14, 1'b1, 1'b0);
    step(e_ins, 1'b1, 1'b0, FLS, 2'b00, 2'b00, "branch_flush_1");
    step(e_ins, 1'b0, 1'b0, FLS, 2'b00, 2'b00, "branch_flush_2");
    step(nop, 1'b0, 1'b0, RUN, 2'b00, 2'b00, "branch_done");

    // Memory hold with a branch landing in the middle of it.
    step(nop, 1'b0, 1'b1, HLD, 2'b00, 2'b00, "hold_1");
    step(nop, 1'b1, 1'b1, HLD, 2'b00, 2'b00, "hold_2_branch");
    step(nop, 1'b0, 1'b1, HLD, 2'b00, 2'b00, "hold_3");
    step(nop, 1'b0, 1'b0, FLS, 2'b00, 2'b00, "pending_flush_1");
    step(nop, 1'b0, 1'b0, FLS, 2'b00, 2'b00, "pending_flush_2");
    step(nop, 1'b0, 1'b0, RUN, 2'b00, 2'b00, "pending_done");

    // Asynchronous reset in the middle of a stall.
    step(ins(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd7, 1'b1, 1'b1), 1'b0, 1'b0, RUN, 2'b00, 2'b00, "reset_producer");
    g_ins = ins(1'b1, 4'd7, 1'b1, 4'd0, 1'b0, 4'd15, 1'b1, 1'b0);
    step(g_ins, 1'b0, 1'b0, STL, 2'b00, 2'b00, "reset_pre_stall");
    #1;
    rst = 1'b1;
    exp_cnt = '0;
    expect_reset("reset_async_mid_stall");
    @(posedge clk);
    #1;
    rst = 1'b0;
    apply_stimulus(g_ins, 1'b0, 1'b0, RUN, 2'b00, 2'b00, "reset_after_release");
    @(negedge clk);
    check_output();
    step(nop, 1'b0, 1'b0, RUN, 2'b00, 2'b00, "reset_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
